fmul_arbiter: RTL and testbench

FMUL_ARBITER -- requirements
Module: fmul_arbiter

---
 rtl/fmul_arbiter.sv | 128 ++++++++++++
 tb/tb_fmul_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fmul_arbiter
// Description : Round-robin sharing of one pipelined fmul among NREQ
//               requesters, with a per-requester result slot.
// Revision    : 1.0 - initial release
// ============================================================================
module fmul_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 1,
    parameter int ID   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [15*NREQ-1:0]   req_x,
    input  logic [15*NREQ-1:0]   req_y,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      res_valid,
    output logic [15*NREQ-1:0]   res_data,
    input  logic [NREQ-1:0]      res_ready,
    output logic [14:0]          mul_x,
    output logic [14:0]          mul_y,
    input  logic [14:0]          mul_r,
    output logic                 busy
);

    localparam int c_IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || LAT < 1 || ID < 0) begin : g_param_check
        $error("fmul_arbiter: parameter out of range");
    end

    logic [c_IDW-1:0] r_rr;
    logic [LAT-1:0]   r_tag_v;
    logic [c_IDW-1:0] r_tag_id [LAT];
    logic [NREQ-1:0]  r_inflight;
    logic [NREQ-1:0]  r_res_valid;
    logic [14:0]      r_res_data [NREQ];

    logic [14:0]      w_x [NREQ];
    logic [14:0]      w_y [NREQ];
    logic [NREQ-1:0]  w_eligible;
    logic [NREQ-1:0]  w_gnt_oh;
    logic [NREQ-1:0]  w_cap_oh;
    logic             w_gnt_any;
    logic [c_IDW-1:0] w_gnt_idx;
    logic [c_IDW-1:0] w_idx;
    logic [c_IDW-1:0] w_rr_next;

    for (genvar i = 0; i < NREQ; i++) begin : g_pack
        assign w_x[i] = req_x[15*i +: 15];
        assign w_y[i] = req_y[15*i +: 15];
        assign res_data[15*i +: 15] = r_res_data[i];
    end

    // A slot being drained this cycle can accept a new operation at once.
    assign w_eligible = req_valid & ~r_inflight & (~r_res_valid | res_ready);

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_gnt_oh  = '0;
        w_idx     = '0;
        mul_x     = '0;
        mul_y     = '0;
        if (rst_n) begin
            for (int k = 0; k < NREQ; k++) begin
                w_idx = c_IDW'((int'(r_rr) + k) % NREQ);
                if (!w_gnt_any && w_eligible[w_idx]) begin
                    w_gnt_any       = 1'b1;
                    w_gnt_idx       = w_idx;
                    w_gnt_oh[w_idx] = 1'b1;
                    mul_x           = w_x[w_idx];
                    mul_y           = w_y[w_idx];
                end
            end
        end
    end

    assign w_rr_next = (w_gnt_idx == c_IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        w_cap_oh = '0;
        if (r_tag_v[LAT-1]) begin
            w_cap_oh[r_tag_id[LAT-1]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr        <= '0;
            r_tag_v     <= '0;
            r_inflight  <= '0;
            r_res_valid <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_tag_id[i] <= '0;
            end
            for (int i = 0; i < NREQ; i++) begin
                r_res_data[i] <= '0;
            end
        end else begin
            if (w_gnt_any) begin
                r_rr <= w_rr_next;
            end
            // Tag pipeline mirrors the fmul latency so the capture lines up with mul_r.
            r_tag_v[0]  <= w_gnt_any;
            r_tag_id[0] <= w_gnt_idx;
            for (int i = 1; i < LAT; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
            r_inflight  <= (r_inflight | w_gnt_oh) & ~w_cap_oh;
            r_res_valid <= (r_res_valid & ~res_ready) | w_cap_oh;
            for (int i = 0; i < NREQ; i++) begin
                if (w_cap_oh[i]) begin
                    r_res_data[i] <= mul_r;
                end
            end
        end
    end

    assign req_ready = w_gnt_oh;
    assign res_valid = r_res_valid;
    assign busy      = (|r_inflight) | (|r_res_valid);

endmodule
`default_nettype wire

// File: tb/tb_fmul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmul_arbiter
// Description : Randomized and directed bench for fmul_arbiter against a
//               cycle-level queue model, with a stand-in pipelined fmul.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmul_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [15*NREQ-1:0]  req_x = '0;
    logic [15*NREQ-1:0]  req_y = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     res_valid;
    logic [15*NREQ-1:0]  res_data;
    logic [NREQ-1:0]     res_ready = '0;
    logic [14:0]         mul_x;
    logic [14:0]         mul_y;
    logic [14:0]         mul_r;
    logic                busy;

    always #5 clk = ~clk;

    fmul_arbiter #(.NREQ(NREQ), .LAT(LAT), .ID(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_r     (mul_r),
        .busy      (busy)
    );

    // Stand-in fmul: known products for the directed operands, NaN passes through.
    function automatic logic [14:0] fake_mul(input logic [14:0] x, input logic [14:0] y);
        if (x == 15'h27C0 && y == 15'h2800) return 15'h2800;
        if (x == 15'h27E0 && y == 15'h27E0) return 15'h2808;
        if (x[14:13] == 2'b11) return 15'h6000;
        return (x ^ {y[6:0], y[14:7]}) + 15'h1234;
    endfunction

    logic [14:0] r_pipe [LAT];
    always_ff @(posedge clk) begin
        r_pipe[0] <= fake_mul(mul_x, mul_y);
        for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
    assign mul_r = r_pipe[LAT-1];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    typedef struct {
        int          due;
        int          req;
        logic [14:0] data;
    } pend_t;

    pend_t       pend[$];
    bit          m_inflight [NREQ];
    bit          m_full     [NREQ];
    logic [14:0] m_data     [NREQ];
    int          m_rr = 0;

    task automatic step(input bit rst, input logic [NREQ-1:0] rv, input logic [NREQ-1:0] rr_in,
                        input logic [15*NREQ-1:0] rx, input logic [15*NREQ-1:0] ry);
        logic [NREQ-1:0]    e_ready;
        logic [NREQ-1:0]    e_valid;
        logic [15*NREQ-1:0] e_data;
        logic [14:0]        e_mx;
        logic [14:0]        e_my;
        logic               e_busy;
        int                 g;
        @(posedge clk);
        #1;
        rst_n     = rst;
        req_valid = rv;
        res_ready = rr_in;
        req_x     = rx;
        req_y     = ry;
        cyc++;
        if (!rst) begin
            pend.delete();
            m_rr = 0;
            for (int i = 0; i < NREQ; i++) begin
                m_inflight[i] = 0;
                m_full[i]     = 0;
                m_data[i]     = '0;
            end
        end else begin
            for (int k = pend.size() - 1; k >= 0; k--) begin
                if (pend[k].due == cyc) begin
                    m_full[pend[k].req]     = 1;
                    m_data[pend[k].req]     = pend[k].data;
                    m_inflight[pend[k].req] = 0;
                    pend.delete(k);
                end
            end
        end
        e_busy = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            e_valid[i]         = m_full[i];
            e_data[15*i +: 15] = m_data[i];
            if (m_full[i] || m_inflight[i]) e_busy = 1'b1;
        end
        g = -1;
        if (rst) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_rr + k) % NREQ;
                if (g < 0 && rv[i] && !m_inflight[i] && (!m_full[i] || rr_in[i])) g = i;
            end
        end
        e_ready = '0;
        e_mx    = '0;
        e_my    = '0;
        if (g >= 0) begin
            e_ready[g] = 1'b1;
            e_mx       = rx[15*g +: 15];
            e_my       = ry[15*g +: 15];
        end
        @(negedge clk);
        check_val("req_ready", req_ready, e_ready);
        check_val("mul_x", mul_x, e_mx);
        check_val("mul_y", mul_y, e_my);
        check_val("res_valid", res_valid, e_valid);
        check_val("res_data", res_data, e_data);
        check_val("busy", busy, e_busy);
        if (rst) begin
            for (int i = 0; i < NREQ; i++) if (m_full[i] && rr_in[i]) m_full[i] = 0;
            if (g >= 0) begin
                m_inflight[g] = 1;
                pend.push_back('{cyc + LAT + 1, g, fake_mul(e_mx, e_my)});
                m_rr = (g + 1) % NREQ;
            end
        end
    endtask

    task automatic idle(input int n, input logic [NREQ-1:0] rr_in);
        for (int k = 0; k < n; k++) step(1'b1, '0, rr_in, '0, '0);
    endtask

    logic [15*NREQ-1:0] vx, vy;
    logic [NREQ-1:0]    oh;
    int                 n1, n_other;

    initial begin
        // Reset state
        step(1'b0, '1, '1, '0, '0);
        step(1'b0, '0, '0, '0, '0);

        // Single request: 1.0 * 2.0
        vx = '0; vy = '0;
        vx[14:0] = 15'h27C0; vy[14:0] = 15'h2800;
        step(1'b1, 4'b0001, '0, vx, vy);
        check_val("single_grant", req_ready, 4'b0001);
        idle(1, '0);
        idle(1, '0);
        check_val("single_res", {res_valid[0], res_data[14:0]}, {1'b1, 15'h2800});
        idle(2, '1);

        // All four requesters with 1.5 * 1.5, from rr = 0
        step(1'b0, '0, '0, '0, '0);
        vx = {4{15'h27E0}}; vy = vx;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, '1, '1, vx, vy);
            if (k < 4) begin
                oh = '0; oh[k] = 1'b1;
                check_val("rr_order", req_ready, oh);
            end
            if (k >= 2) check_val("rr_res", {res_valid[k-2], res_data[15*(k-2) +: 15]}, {1'b1, 15'h2808});
        end
        idle(6, '1);

        // Backpressure on requester 1
        n1 = 0; n_other = 0;
        for (int k = 0; k < 14; k++) begin
            vx = {$urandom, $urandom}; vy = {$urandom, $urandom};
            step(1'b1, '1, 4'b1101, vx, vy);
            n1      += int'(req_ready[1]);
            n_other += int'(req_ready[0] | req_ready[2] | req_ready[3]);
        end
        check_val("bp_grants1", n1, 1);
        check_val("bp_others", n_other > 0, 1);
        idle(6, '1);

        // Reset one cycle after a grant
        step(1'b1, 4'b0100, '1, {4{15'h1111}}, {4{15'h2222}});
        step(1'b0, '0, '0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            idle(1, '0);
            check_val("rst_res_valid", res_valid, 4'b0000);
            check_val("rst_busy", busy, 1'b0);
        end
        step(1'b1, '1, '1, {4{15'h0123}}, {4{15'h0456}});
        check_val("rst_rr", req_ready, 4'b0001);
        idle(4, '1);

        // Exception pass-through
        step(1'b0, '0, '0, '0, '0);
        vx = '0; vy = '0;
        vx[59:45] = 15'h6000; vy[59:45] = 15'h27C0;
        step(1'b1, 4'b1000, '0, vx, vy);
        idle(2, '0);
        check_val("nan_exc", {res_valid[3], res_data[59:58]}, {1'b1, 2'b11});
        check_val("nan_data", res_data[59:45], 15'h6000);
        idle(2, '1);

        // Random traffic
        for (int k = 0; k < 800; k++) begin
            vx = {$urandom, $urandom}; vy = {$urandom, $urandom};
            step($urandom_range(99) != 0, NREQ'($urandom), NREQ'($urandom | $urandom), vx, vy);
        end
        idle(4, '1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
